// File: rtl/ball_detector_pkg.sv
// Shared definitions for the ball-detector pixel path: HSV widths, hue base
// angles, converter FSM states and the color-class codes used by the classifier.
package ball_detector_pkg;

    localparam int HUE_W      = 9;
    localparam int SV_W       = 5;
    localparam int HCNT_W     = 10;
    localparam int HUE_SECTOR = 60;
    localparam int SV_MAX     = 31;

    localparam logic [HUE_W-1:0] HUE_BASE_G = 9'd120;
    localparam logic [HUE_W-1:0] HUE_BASE_B = 9'd240;
    localparam logic [HUE_W-1:0] HUE_FULL   = 9'd360;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        OUT
    } state_t;

    typedef enum logic [1:0] {
        MAX_R,
        MAX_G,
        MAX_B
    } max_sel_t;

    typedef enum logic [2:0] {
        CLASS_NONE,
        CLASS_RED,
        CLASS_ORANGE,
        CLASS_YELLOW,
        CLASS_GREEN,
        CLASS_BLUE
    } color_class_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: DIV_W-bit dividend, 5-bit divisor, one quotient bit per
// cycle. The first bit is resolved on the start edge, so done pulses DIV_W-1 cycles later.
module seq_divider #(
    parameter int DIV_W = 11,
    parameter int Q_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] dividend,
    input  logic [4:0]       divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(DIV_W);

    logic [DIV_W-1:0] quo;
    logic [4:0]       rem;
    logic [4:0]       div_q;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    logic [DIV_W-1:0] shift_src;
    logic [4:0]       div_use;
    logic [5:0]       trial;
    logic [5:0]       trial_sub;
    logic             ge;
    logic [4:0]       rem_next;
    logic [DIV_W-1:0] quo_next;

    // Remainder stays below the divisor (<=31), so the shifted trial fits 6 bits.
    always_comb begin
        shift_src = start ? dividend : quo;
        div_use   = start ? divisor : div_q;
        trial     = {(start ? 5'd0 : rem), shift_src[DIV_W-1]};
        trial_sub = trial - {1'b0, div_use};
        ge        = (trial >= {1'b0, div_use});
        rem_next  = ge ? trial_sub[4:0] : trial[4:0];
        quo_next  = {shift_src[DIV_W-2:0], ge};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo   <= '0;
            rem   <= '0;
            div_q <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            quo   <= quo_next;
            rem   <= rem_next;
            div_q <= divisor;
            cnt   <= CNT_W'(DIV_W - 1);
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            quo <= quo_next;
            rem <= rem_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = quo[Q_W-1:0];

endmodule

// File: rtl/rgb_to_hsv_stream.sv
// RGB565 to HSV converter feeding the color classifier: one pixel per DIV_W+1
// cycles through a valid/ready handshake, with a per-line pixel index.
module rgb_to_hsv_stream #(
    parameter int DIV_W  = 11,
    parameter int HCNT_W = ball_detector_pkg::HCNT_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    input  logic [15:0]                        rgb565,
    input  logic                               line_start,
    input  logic                               frame_start,
    output logic [ball_detector_pkg::HUE_W-1:0] hue,
    output logic [ball_detector_pkg::SV_W-1:0]  saturation,
    output logic [ball_detector_pkg::SV_W-1:0]  value,
    output logic                               write,
    output logic [HCNT_W-1:0]                  horiz_count
);

    import ball_detector_pkg::*;

    state_t state, state_d;
    logic   accept;

    logic [4:0]       r, g, b, mx, mn, d, diff_mag;
    logic             diff_neg;
    max_sel_t         sel;
    logic [DIV_W-1:0] hue_dividend, sat_dividend;
    logic [4:0]       hue_divisor, sat_divisor;
    logic             g_lsb_unused;

    logic [4:0]        cap_val;
    max_sel_t          cap_sel;
    logic              cap_neg, cap_dzero, cap_mzero;
    logic [HCNT_W-1:0] cap_hcnt, pix_cnt;

    logic [5:0]       hue_quo;
    logic [4:0]       sat_quo;
    logic             div_done, sat_done_unused;
    logic             div_start, finish;
    logic [HUE_W-1:0] hue_calc;

    // Green is reduced to 5 bits so all three channels share one scale.
    always_comb begin
        r            = rgb565[15:11];
        g            = rgb565[10:6];
        b            = rgb565[4:0];
        g_lsb_unused = rgb565[5];
        if (r >= g && r >= b) begin
            sel      = MAX_R;
            mx       = r;
            diff_neg = (g < b);
            diff_mag = diff_neg ? (b - g) : (g - b);
        end else if (g >= b) begin
            sel      = MAX_G;
            mx       = g;
            diff_neg = (b < r);
            diff_mag = diff_neg ? (r - b) : (b - r);
        end else begin
            sel      = MAX_B;
            mx       = b;
            diff_neg = (r < g);
            diff_mag = diff_neg ? (g - r) : (r - g);
        end
        mn           = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
        d            = mx - mn;
        hue_dividend = DIV_W'(diff_mag) * DIV_W'(HUE_SECTOR);
        sat_dividend = DIV_W'(d) * DIV_W'(SV_MAX);
        hue_divisor  = (d == 5'd0) ? 5'd1 : d;
        sat_divisor  = (mx == 5'd0) ? 5'd1 : mx;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state;
        pix_ready = 1'b1;
        write     = 1'b0;
        unique case (state)
            IDLE: if (accept) state_d = DIV;
            DIV: begin
                pix_ready = 1'b0;
                if (frame_start)   state_d = IDLE;
                else if (div_done) state_d = OUT;
            end
            OUT: begin
                write   = 1'b1;
                state_d = accept ? DIV : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = pix_valid && pix_ready && !frame_start;
    assign div_start = accept;
    assign finish    = (state == DIV) && div_done && !frame_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    seq_divider #(.DIV_W(DIV_W), .Q_W(6)) u_hue_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (frame_start),
        .dividend (hue_dividend),
        .divisor  (hue_divisor),
        .quotient (hue_quo),
        .done     (div_done)
    );

    seq_divider #(.DIV_W(DIV_W), .Q_W(5)) u_sat_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (frame_start),
        .dividend (sat_dividend),
        .divisor  (sat_divisor),
        .quotient (sat_quo),
        .done     (sat_done_unused)
    );

    // Pixel index: a same-cycle line_start gives this pixel 0 and leaves 1 behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt  <= '0;
            cap_hcnt <= '0;
        end else if (frame_start) begin
            pix_cnt <= '0;
        end else if (accept) begin
            cap_hcnt <= line_start ? '0 : pix_cnt;
            if (line_start)       pix_cnt <= HCNT_W'(1);
            else if (~&pix_cnt)   pix_cnt <= pix_cnt + 1'b1;
        end else if (line_start) begin
            pix_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_val   <= '0;
            cap_sel   <= MAX_R;
            cap_neg   <= 1'b0;
            cap_dzero <= 1'b1;
            cap_mzero <= 1'b1;
        end else if (accept) begin
            cap_val   <= mx;
            cap_sel   <= sel;
            cap_neg   <= diff_neg;
            cap_dzero <= (d == 5'd0);
            cap_mzero <= (mx == 5'd0);
        end
    end

    always_comb begin
        hue_calc = '0;
        unique case (cap_sel)
            MAX_R:   hue_calc = !cap_neg ? HUE_W'(hue_quo) :
                                (hue_quo == 6'd0) ? '0 : HUE_FULL - HUE_W'(hue_quo);
            MAX_G:   hue_calc = cap_neg ? HUE_BASE_G - HUE_W'(hue_quo) : HUE_BASE_G + HUE_W'(hue_quo);
            MAX_B:   hue_calc = cap_neg ? HUE_BASE_B - HUE_W'(hue_quo) : HUE_BASE_B + HUE_W'(hue_quo);
            default: hue_calc = '0;
        endcase
        if (cap_dzero) hue_calc = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hue         <= '0;
            saturation  <= '0;
            value       <= '0;
            horiz_count <= '0;
        end else if (finish) begin
            hue         <= hue_calc;
            saturation  <= cap_mzero ? '0 : sat_quo;
            value       <= cap_val;
            horiz_count <= cap_hcnt;
        end
    end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Self-checking bench for rgb_to_hsv_stream: fixed color vectors, back-to-back
// streaming, abort/reset corners and a long random run against an arithmetic HSV model.
module tb_rgb_to_hsv_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] rgb565;
    logic        line_start;
    logic        frame_start;
    logic [8:0]  hue;
    logic [4:0]  saturation;
    logic [4:0]  value;
    logic        write;
    logic [9:0]  horiz_count;

    int checks   = 0;
    int failures = 0;
    int hc       = 0;

    typedef struct {
        logic [15:0] rgb;
        int          hue;
        int          sat;
        int          val;
    } vec_t;

    vec_t vecs[7];

    rgb_to_hsv_stream dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .rgb565      (rgb565),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hue         (hue),
        .saturation  (saturation),
        .value       (value),
        .write       (write),
        .horiz_count (horiz_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // HSV from the textbook definition on integer channels.
    function automatic void ref_hsv(input logic [15:0] p, output int h, output int s, output int v);
        int r, g, b, mx, mn, d, q;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]) / 2;
        b  = int'(p[4:0]);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d  = mx - mn;
        v  = mx;
        s  = (mx == 0) ? 0 : (d * 31) / mx;
        if (d == 0) begin
            h = 0;
        end else if (r >= g && r >= b) begin
            q = (60 * ((g >= b) ? g - b : b - g)) / d;
            h = (g >= b) ? q : ((q == 0) ? 0 : 360 - q);
        end else if (g >= b) begin
            q = (60 * ((b >= r) ? b - r : r - b)) / d;
            h = (b >= r) ? 120 + q : 120 - q;
        end else begin
            q = (60 * ((r >= g) ? r - g : g - r)) / d;
            h = (r >= g) ? 240 + q : 240 - q;
        end
    endfunction

    task automatic model_accept(input bit ls, output int exp_h);
        if (ls) begin
            exp_h = 0;
            hc    = 1;
        end else begin
            exp_h = hc;
            if (hc < 1023) hc++;
        end
    endtask

    task automatic pulse_frame_start();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        hc = 0;
    endtask

    task automatic watch_no_write(input string name, input int cycles);
        int wr;
        wr = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (write) wr++;
        end
        check(name, wr, 0);
    endtask

    // Offer one pixel, wait for its write strobe and compare everything it carries.
    task automatic run_pixel(input logic [15:0] p, input bit ls, input int eh, input int es,
                             input int ev, input string tag);
        int wait_c, lat, eh_cnt;
        @(negedge clk);
        pix_valid  = 1'b1;
        rgb565     = p;
        line_start = ls;
        wait_c     = 0;
        while (!pix_ready && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        if (!pix_ready) begin
            check({tag, "_ready_timeout"}, 0, 1);
            pix_valid  = 1'b0;
            line_start = 1'b0;
            return;
        end
        model_accept(ls, eh_cnt);
        @(posedge clk);
        #1;
        pix_valid  = 1'b0;
        line_start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!write && lat < 40);
        check({tag, "_latency"}, lat, 11);
        check({tag, "_hue"}, int'(hue), eh);
        check({tag, "_sat"}, int'(saturation), es);
        check({tag, "_val"}, int'(value), ev);
        check({tag, "_hcnt"}, int'(horiz_count), eh_cnt);
    endtask

    initial begin
        logic [15:0] pv[4];
        int          hx[4];
        int          eh, es, ev, low, held_hue;
        logic [15:0] p;

        vecs[0] = '{16'hF800, 0,   31, 31};
        vecs[1] = '{16'h07E0, 120, 31, 31};
        vecs[2] = '{16'h001F, 240, 31, 31};
        vecs[3] = '{16'h8410, 0,   0,  16};
        vecs[4] = '{16'h0000, 0,   0,  0};
        vecs[5] = '{16'hF80F, 331, 31, 31};
        vecs[6] = '{16'hFFE0, 60,  31, 31};

        rst         = 1'b1;
        pix_valid   = 1'b0;
        rgb565      = '0;
        line_start  = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(pix_ready), 1);
        check("reset_write", int'(write), 0);
        check("reset_hue", int'(hue), 0);
        check("reset_sat", int'(saturation), 0);
        check("reset_val", int'(value), 0);
        check("reset_hcnt", int'(horiz_count), 0);
        @(negedge clk);
        rst = 1'b0;
        hc  = 0;

        for (int i = 0; i < 7; i++)
            run_pixel(vecs[i].rgb, 1'b0, vecs[i].hue, vecs[i].sat, vecs[i].val,
                      $sformatf("vec%0d", i));
        held_hue = vecs[6].hue;

        // frame_start during DIV: no write, outputs hold, counter cleared.
        @(negedge clk);
        pix_valid = 1'b1;
        rgb565    = 16'h07E0;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        repeat (4) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        hc = 0;
        check("abort_ready", int'(pix_ready), 1);
        check("abort_hue_held", int'(hue), held_hue);
        watch_no_write("abort_no_write", 15);
        run_pixel(16'hF800, 1'b0, 0, 31, 31, "after_abort");

        // frame_start coinciding with an offered pixel drops it.
        @(negedge clk);
        pix_valid   = 1'b1;
        rgb565      = 16'h001F;
        frame_start = 1'b1;
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        hc = 0;
        check("drop_ready", int'(pix_ready), 1);
        watch_no_write("drop_no_write", 15);

        // rst during DIV: immediate reset values, no write, counter cleared.
        run_pixel(16'h07E0, 1'b0, 120, 31, 31, "pre_rst");
        @(negedge clk);
        pix_valid = 1'b1;
        rgb565    = 16'hF80F;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(pix_ready), 1);
        check("midrst_write", int'(write), 0);
        check("midrst_hue", int'(hue), 0);
        check("midrst_hcnt", int'(horiz_count), 0);
        @(negedge clk);
        rst = 1'b0;
        hc  = 0;
        watch_no_write("midrst_no_write", 15);
        run_pixel(16'h001F, 1'b0, 240, 31, 31, "after_rst");

        // Back-to-back stream with line_start during the third pixel's DIV.
        pulse_frame_start();
        pv[0] = 16'hF800; pv[1] = 16'h07E0; pv[2] = 16'h001F; pv[3] = 16'hF80F;
        hx[0] = 0; hx[1] = 1; hx[2] = 2; hx[3] = 0;
        @(negedge clk);
        pix_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rgb565 = pv[k];
            check($sformatf("b2b%0d_ready", k), int'(pix_ready), 1);
            @(posedge clk);
            low = 0;
            for (int c = 0; c < 11; c++) begin
                @(negedge clk);
                line_start = (k == 2 && c == 4);
                if (!pix_ready && !write) low++;
            end
            check($sformatf("b2b%0d_ready_low", k), low, 11);
            @(negedge clk);
            if (k == 3) pix_valid = 1'b0;
            ref_hsv(pv[k], eh, es, ev);
            check($sformatf("b2b%0d_write", k), int'(write), 1);
            check($sformatf("b2b%0d_hue", k), int'(hue), eh);
            check($sformatf("b2b%0d_sat", k), int'(saturation), es);
            check($sformatf("b2b%0d_val", k), int'(value), ev);
            check($sformatf("b2b%0d_hcnt", k), int'(horiz_count), hx[k]);
        end
        hc = 1;
        @(posedge clk);
        #1;
        check("b2b_end_write", int'(write), 0);
        check("b2b_end_ready", int'(pix_ready), 1);

        // Random pixels with occasional line_start.
        for (int i = 0; i < 40; i++) begin
            p = 16'($urandom);
            ref_hsv(p, eh, es, ev);
            run_pixel(p, ($urandom_range(0, 5) == 0), eh, es, ev, $sformatf("rls%0d", i));
        end

        // Long random line, long enough to drive the pixel index into saturation.
        pulse_frame_start();
        for (int i = 0; i < 1030; i++) begin
            p = 16'($urandom);
            if ($urandom_range(0, 7) == 0) p[10:5] = {p[15:11], p[15]};
            if ($urandom_range(0, 7) == 0) p[4:0]  = p[15:11];
            ref_hsv(p, eh, es, ev);
            run_pixel(p, 1'b0, eh, es, ev, $sformatf("rnd%0d", i));
        end
        check("hcnt_saturated", int'(horiz_count), 1023);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
